// File: rtl/aw_channel.sv
// Write-address stage of the AXI downsizer: splits one wide AW burst into narrow AW bursts
// and feeds per-beat sub-transfer counts to the W splitter. Optional: AW_BURST_CHECK_EN.
module aw_channel #(
    parameter int ADDR_WIDTH    = 32,
    parameter int M_DATA_WIDTH  = 128,
    parameter int S_DATA_WIDTH  = 32,
    parameter int MAX_SUB_TRANS = M_DATA_WIDTH / S_DATA_WIDTH,
    parameter int MAX_BURST_LEN = 256,
    parameter int W_FIFO_DEPTH  = 8,
    parameter int XFER_D_IN     = 3
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic [ADDR_WIDTH-1:0] m_awaddr,
    input  logic [7:0]            m_awlen,
    input  logic [2:0]            m_awsize,
    input  logic [1:0]            m_awburst,
    input  logic                  m_awvalid,
    output logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] s_awaddr,
    output logic [7:0]            s_awlen,
    output logic [2:0]            s_awsize,
    output logic [1:0]            s_awburst,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [XFER_D_IN-1:0]  xfer_data_o,
    output logic                  xfer_empty_o,
    input  logic                  xfer_rd_valid_i,
    output logic [7:0]            b_split_cnt,
    output logic                  b_info_valid,
    output logic                  burst_err
);

    localparam int S_SIZE      = $clog2(S_DATA_WIDTH / 8);
    localparam int SUB_SHIFT   = $clog2(MAX_SUB_TRANS);
    localparam int BURST_SHIFT = $clog2(MAX_BURST_LEN);
    localparam int PTR_W       = $clog2(W_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [2:0]             size_reg;
    logic [XFER_D_IN-1:0]   r_reg;
    logic [10:0]            rem_reg;
    logic [8:0]             push_cnt_reg;
    logic [8:0]             push_cnt_next;
    logic [7:0]             b_split_cnt_reg;
    logic                   b_info_valid_reg;

    logic                   m_hs, s_hs;
    logic [2:0]             size_eff, size_calc, r_shift;
    logic [10:0]            r_calc, t_calc;
    logic [11:0]            split_calc;
    logic [7:0]             burst_len;
    logic [10:0]            burst_beats;
    logic [ADDR_WIDTH-1:0]  addr_step;

    logic [XFER_D_IN-1:0]   fifo_mem [W_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]         fifo_cnt_reg;
    logic                   fifo_full, fifo_empty, push_en, pop_en;

    assign m_hs = m_awvalid && m_awready;
    assign s_hs = s_awvalid && s_awready;

    // Sizes wider than the wide bus are clamped so R never exceeds MAX_SUB_TRANS.
    always_comb begin
        if (m_awsize > 3'(S_SIZE + SUB_SHIFT))
            size_eff = 3'(S_SIZE + SUB_SHIFT);
        else
            size_eff = m_awsize;
        if (size_eff > 3'(S_SIZE)) begin
            r_shift   = size_eff - 3'(S_SIZE);
            size_calc = 3'(S_SIZE);
        end else begin
            r_shift   = 3'd0;
            size_calc = size_eff;
        end
        r_calc     = 11'd1 << r_shift;
        t_calc     = ({3'd0, m_awlen} + 11'd1) * r_calc;
        split_calc = ({1'b0, t_calc} + 12'(MAX_BURST_LEN - 1)) >> BURST_SHIFT;
    end

    always_comb begin
        if (rem_reg >= 11'(MAX_BURST_LEN))
            burst_len = 8'(MAX_BURST_LEN - 1);
        else
            burst_len = 8'(rem_reg - 11'd1);
        burst_beats = {3'd0, burst_len} + 11'd1;
        addr_step   = ADDR_WIDTH'(burst_beats) << size_reg;
    end

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign fifo_full     = fifo_cnt_reg[PTR_W];
    assign fifo_empty    = (fifo_cnt_reg == '0);
    assign push_en       = (push_cnt_reg != 9'd0) && !fifo_full;
    assign pop_en        = xfer_rd_valid_i && !fifo_empty;
    assign push_cnt_next = push_cnt_reg - 9'(push_en);

    always_comb begin
        state_next = state_reg;
        m_awready  = 1'b0;
        s_awvalid  = 1'b0;
        case (state_reg)
            IDLE: begin
                m_awready = 1'b1;
                if (m_awvalid)
                    state_next = ISSUE;
            end
            ISSUE: begin
                s_awvalid = 1'b1;
                if (s_awready && (rem_reg == burst_beats))
                    state_next = (push_cnt_next != 9'd0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (push_cnt_next == 9'd0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            addr_reg         <= '0;
            size_reg         <= '0;
            r_reg            <= '0;
            rem_reg          <= '0;
            push_cnt_reg     <= '0;
            b_split_cnt_reg  <= '0;
            b_info_valid_reg <= 1'b0;
        end else begin
            b_info_valid_reg <= m_hs;
            if (m_hs) begin
                addr_reg        <= m_awaddr;
                size_reg        <= size_calc;
                r_reg           <= XFER_D_IN'(r_calc);
                rem_reg         <= t_calc;
                push_cnt_reg    <= {1'b0, m_awlen} + 9'd1;
                b_split_cnt_reg <= 8'(split_calc);
            end else begin
                push_cnt_reg <= push_cnt_next;
                if (s_hs) begin
                    rem_reg  <= rem_reg - burst_beats;
                    addr_reg <= addr_reg + addr_step;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push_en)
            fifo_mem[wr_ptr_reg] <= r_reg;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_en, pop_en})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    assign xfer_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign xfer_empty_o = fifo_empty;

    // Narrow fields read as zero outside ISSUE; they only move on a narrow handshake.
    assign s_awaddr  = (state_reg == ISSUE) ? addr_reg : '0;
    assign s_awlen   = (state_reg == ISSUE) ? burst_len : 8'd0;
    assign s_awsize  = (state_reg == ISSUE) ? size_reg : 3'd0;
    assign s_awburst = (state_reg == ISSUE) ? 2'b01 : 2'b00;

    assign b_split_cnt  = b_split_cnt_reg;
    assign b_info_valid = b_info_valid_reg;

`ifdef AW_BURST_CHECK_EN
    logic burst_err_reg;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n)
            burst_err_reg <= 1'b0;
        else if (m_hs && (m_awburst != 2'b01))
            burst_err_reg <= 1'b1;
    end

    assign burst_err = burst_err_reg;
`else
    logic unused_awburst;
    assign unused_awburst = ^m_awburst;
    assign burst_err      = 1'b0;
`endif

endmodule

// File: tb/tb_aw_channel.sv
// Directed bench for aw_channel: one task per scenario, inline checks against hand-computed values.
module tb_aw_channel;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] m_awaddr = '0;
    logic [7:0]  m_awlen = '0;
    logic [2:0]  m_awsize = '0;
    logic [1:0]  m_awburst = 2'b01;
    logic        m_awvalid = 1'b0;
    logic        m_awready;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready = 1'b0;
    logic [2:0]  xfer_data_o;
    logic        xfer_empty_o;
    logic        xfer_rd_valid_i = 1'b0;
    logic [7:0]  b_split_cnt;
    logic        b_info_valid;
    logic        burst_err;

`ifdef AW_BURST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [2:0]  pop_q[$];

    aw_channel dut (
        .aclk(aclk), .arst_n(arst_n),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .xfer_data_o(xfer_data_o), .xfer_empty_o(xfer_empty_o), .xfer_rd_valid_i(xfer_rd_valid_i),
        .b_split_cnt(b_split_cnt), .b_info_valid(b_info_valid), .burst_err(burst_err)
    );

    always #5 aclk = ~aclk;

    // Inputs change just after posedge, so negedge sees what the next posedge will act on.
    always @(negedge aclk) begin
        if (arst_n) begin
            if (s_awvalid && s_awready) begin
                aw_addr_q.push_back(s_awaddr);
                aw_len_q.push_back(s_awlen);
                $display("narrow aw: addr=%08h len=%0d size=%0d", s_awaddr, s_awlen, s_awsize);
            end
            if (xfer_rd_valid_i && !xfer_empty_o)
                pop_q.push_back(xfer_data_o);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_q();
        aw_addr_q.delete();
        aw_len_q.delete();
        pop_q.delete();
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        m_awaddr  = addr;
        m_awlen   = len;
        m_awsize  = size;
        m_awburst = burst;
        m_awvalid = 1'b1;
        step();
        m_awvalid = 1'b0;
        $display("wide aw: addr=%08h len=%0d size=%0d burst=%0d", addr, len, size, burst);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (m_awready !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) step();
        checks++; if (m_awready !== 1'b1) begin errors++; $display("FAIL rst_m_awready: got %b expected 1", m_awready); end
        checks++; if (s_awvalid !== 1'b0) begin errors++; $display("FAIL rst_s_awvalid: got %b expected 0", s_awvalid); end
        checks++; if ({s_awaddr, s_awlen, s_awsize, s_awburst} !== 45'd0) begin errors++; $display("FAIL rst_s_fields: got %h/%h/%h/%h expected 0", s_awaddr, s_awlen, s_awsize, s_awburst); end
        checks++; if (xfer_empty_o !== 1'b1 || xfer_data_o !== 3'd0) begin errors++; $display("FAIL rst_fifo: got empty=%b data=%0d expected 1/0", xfer_empty_o, xfer_data_o); end
        checks++; if (b_split_cnt !== 8'd0 || b_info_valid !== 1'b0 || burst_err !== 1'b0) begin errors++; $display("FAIL rst_b: got %0d/%b/%b expected 0/0/0", b_split_cnt, b_info_valid, burst_err); end
        arst_n = 1'b1;
        step();
        checks++; if (m_awready !== 1'b1 || s_awvalid !== 1'b0) begin errors++; $display("FAIL rst_release: got ready=%b valid=%b expected 1/0", m_awready, s_awvalid); end
    endtask

    task automatic test_single();
        int cyc;
        s_awready = 1'b1;
        xfer_rd_valid_i = 1'b0;
        clear_q();
        send_aw(32'h1000, 8'd3, 3'd4, 2'b01);
        checks++; if (m_awready !== 1'b0 || s_awvalid !== 1'b1) begin errors++; $display("FAIL single_hs: got ready=%b valid=%b expected 0/1", m_awready, s_awvalid); end
        checks++; if (s_awaddr !== 32'h1000 || s_awlen !== 8'd15 || s_awsize !== 3'd2 || s_awburst !== 2'b01) begin errors++; $display("FAIL single_fields: got %h/%0d/%0d/%0d expected 1000/15/2/1", s_awaddr, s_awlen, s_awsize, s_awburst); end
        checks++; if (b_info_valid !== 1'b1 || b_split_cnt !== 8'd1) begin errors++; $display("FAIL single_binfo: got %b/%0d expected 1/1", b_info_valid, b_split_cnt); end
        checks++; if (xfer_empty_o !== 1'b1) begin errors++; $display("FAIL single_empty_n1: got %b expected 1", xfer_empty_o); end
        step();
        checks++; if (xfer_empty_o !== 1'b0 || b_info_valid !== 1'b0 || s_awvalid !== 1'b0) begin errors++; $display("FAIL single_n2: got empty=%b binfo=%b valid=%b expected 0/0/0", xfer_empty_o, b_info_valid, s_awvalid); end
        wait_idle(20, cyc);
        checks++; if (m_awready !== 1'b1 || cyc !== 3) begin errors++; $display("FAIL single_ready_return: got ready=%b after %0d cycles expected 1 after 3", m_awready, cyc); end
        xfer_rd_valid_i = 1'b1;
        repeat (6) step();
        xfer_rd_valid_i = 1'b0;
        checks++; if (pop_q.size() !== 4 || aw_len_q.size() !== 1) begin errors++; $display("FAIL single_counts: got pops=%0d bursts=%0d expected 4/1", pop_q.size(), aw_len_q.size()); end
        foreach (pop_q[i]) begin
            checks++; if (pop_q[i] !== 3'd4) begin errors++; $display("FAIL single_pop%0d: got %0d expected 4", i, pop_q[i]); end
        end
        checks++; if (xfer_empty_o !== 1'b1) begin errors++; $display("FAIL single_drained: got %b expected 1", xfer_empty_o); end
    endtask

    task automatic test_split();
        int cyc;
        logic [31:0] exp_addr;
        s_awready = 1'b1;
        xfer_rd_valid_i = 1'b1;
        clear_q();
        send_aw(32'h0, 8'd255, 3'd4, 2'b01);
        checks++; if (b_split_cnt !== 8'd4 || s_awlen !== 8'd255) begin errors++; $display("FAIL split_first: got cnt=%0d len=%0d expected 4/255", b_split_cnt, s_awlen); end
        wait_idle(600, cyc);
        checks++; if (m_awready !== 1'b1) begin errors++; $display("FAIL split_timeout: got ready=%b after %0d cycles expected 1", m_awready, cyc); end
        repeat (3) step();
        xfer_rd_valid_i = 1'b0;
        checks++; if (aw_addr_q.size() !== 4) begin errors++; $display("FAIL split_bursts: got %0d expected 4", aw_addr_q.size()); end
        foreach (aw_addr_q[i]) begin
            exp_addr = 32'(i) * 32'h400;
            checks++; if (aw_addr_q[i] !== exp_addr || aw_len_q[i] !== 8'd255) begin errors++; $display("FAIL split_burst%0d: got %h/%0d expected %h/255", i, aw_addr_q[i], aw_len_q[i], exp_addr); end
        end
        checks++; if (pop_q.size() !== 256) begin errors++; $display("FAIL split_pops: got %0d expected 256", pop_q.size()); end
        foreach (pop_q[i]) begin
            checks++; if (pop_q[i] !== 3'd4) begin errors++; $display("FAIL split_pop%0d: got %0d expected 4", i, pop_q[i]); end
        end
    endtask

    task automatic test_fifo_full();
        int cyc;
        s_awready = 1'b1;
        xfer_rd_valid_i = 1'b0;
        clear_q();
        send_aw(32'h500, 8'd9, 3'd2, 2'b01);
        checks++; if (s_awlen !== 8'd9 || s_awsize !== 3'd2 || b_split_cnt !== 8'd1) begin errors++; $display("FAIL full_fields: got %0d/%0d/%0d expected 9/2/1", s_awlen, s_awsize, b_split_cnt); end
        repeat (20) step();
        checks++; if (m_awready !== 1'b0 || xfer_empty_o !== 1'b0) begin errors++; $display("FAIL full_stall: got ready=%b empty=%b expected 0/0", m_awready, xfer_empty_o); end
        xfer_rd_valid_i = 1'b1;
        repeat (2) step();
        xfer_rd_valid_i = 1'b0;
        checks++; if (pop_q.size() !== 2) begin errors++; $display("FAIL full_two_pops: got %0d expected 2", pop_q.size()); end
        wait_idle(10, cyc);
        checks++; if (m_awready !== 1'b1) begin errors++; $display("FAIL full_resume: got ready=%b after %0d cycles expected 1", m_awready, cyc); end
        xfer_rd_valid_i = 1'b1;
        repeat (10) step();
        xfer_rd_valid_i = 1'b0;
        checks++; if (pop_q.size() !== 10 || xfer_empty_o !== 1'b1) begin errors++; $display("FAIL full_total: got pops=%0d empty=%b expected 10/1", pop_q.size(), xfer_empty_o); end
        foreach (pop_q[i]) begin
            checks++; if (pop_q[i] !== 3'd1) begin errors++; $display("FAIL full_pop%0d: got %0d expected 1", i, pop_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        s_awready = 1'b0;
        xfer_rd_valid_i = 1'b1;
        clear_q();
        send_aw(32'h2000, 8'd1, 3'd3, 2'b01);
        for (int i = 0; i < 5; i++) begin
            checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h2000 || s_awlen !== 8'd3 || s_awsize !== 3'd2) begin errors++; $display("FAIL bp_hold%0d: got %b/%h/%0d/%0d expected 1/2000/3/2", i, s_awvalid, s_awaddr, s_awlen, s_awsize); end
            step();
        end
        s_awready = 1'b1;
        wait_idle(20, cyc);
        checks++; if (m_awready !== 1'b1) begin errors++; $display("FAIL bp_timeout: got ready=%b after %0d cycles expected 1", m_awready, cyc); end
        repeat (2) step();
        xfer_rd_valid_i = 1'b0;
        checks++; if (aw_addr_q.size() !== 1 || pop_q.size() !== 2) begin errors++; $display("FAIL bp_counts: got bursts=%0d pops=%0d expected 1/2", aw_addr_q.size(), pop_q.size()); end
        foreach (pop_q[i]) begin
            checks++; if (pop_q[i] !== 3'd2) begin errors++; $display("FAIL bp_pop%0d: got %0d expected 2", i, pop_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        s_awready = 1'b1;
        xfer_rd_valid_i = 1'b1;
        clear_q();
        send_aw(32'h10000, 8'd255, 3'd4, 2'b01);
        step();
        checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h10400) begin errors++; $display("FAIL mid_second: got %b/%h expected 1/10400", s_awvalid, s_awaddr); end
        arst_n = 1'b0;
        #1;
        checks++; if (s_awvalid !== 1'b0 || m_awready !== 1'b1 || xfer_empty_o !== 1'b1) begin errors++; $display("FAIL mid_async: got valid=%b ready=%b empty=%b expected 0/1/1", s_awvalid, m_awready, xfer_empty_o); end
        step();
        arst_n = 1'b1;
        step();
        clear_q();
        send_aw(32'h3000, 8'd0, 3'd2, 2'b01);
        checks++; if (s_awaddr !== 32'h3000 || s_awlen !== 8'd0 || s_awsize !== 3'd2 || b_split_cnt !== 8'd1) begin errors++; $display("FAIL mid_after: got %h/%0d/%0d/%0d expected 3000/0/2/1", s_awaddr, s_awlen, s_awsize, b_split_cnt); end
        wait_idle(20, cyc);
        repeat (3) step();
        xfer_rd_valid_i = 1'b0;
        checks++; if (m_awready !== 1'b1 || aw_addr_q.size() !== 1 || pop_q.size() !== 1) begin errors++; $display("FAIL mid_complete: got ready=%b bursts=%0d pops=%0d expected 1/1/1", m_awready, aw_addr_q.size(), pop_q.size()); end
        if (pop_q.size() == 1) begin
            checks++; if (pop_q[0] !== 3'd1) begin errors++; $display("FAIL mid_pop: got %0d expected 1", pop_q[0]); end
        end
    endtask

    task automatic test_burst_err();
        int cyc;
        s_awready = 1'b1;
        xfer_rd_valid_i = 1'b1;
        send_aw(32'h4000, 8'd0, 3'd2, 2'b10);
        checks++; if (burst_err !== EXP_ERR || s_awburst !== 2'b01) begin errors++; $display("FAIL err_set: got err=%b burst=%0d expected %b/1", burst_err, s_awburst, EXP_ERR); end
        wait_idle(20, cyc);
        step();
        send_aw(32'h5000, 8'd0, 3'd2, 2'b01);
        checks++; if (burst_err !== EXP_ERR) begin errors++; $display("FAIL err_sticky: got %b expected %b", burst_err, EXP_ERR); end
        wait_idle(20, cyc);
        checks++; if (burst_err !== EXP_ERR || m_awready !== 1'b1) begin errors++; $display("FAIL err_end: got err=%b ready=%b expected %b/1", burst_err, m_awready, EXP_ERR); end
        xfer_rd_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_fifo_full();
        test_backpressure();
        test_reset_mid();
        test_burst_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
